// File: rtl/vga_out_stage_if.sv
// ---------------------------------------------------------------------------
// vga_out_stage_if
//
// Pixel-request bus between the VGA output stage and the upstream pixel
// generator. The output stage owns the raster position and publishes it
// every cycle. The generator answers with a 6-bit colour PIX_LATENCY
// cycles later.
//
// Signals
//   x           raster column, 0..H_TOTAL-1          (stage -> generator)
//   y           raster line,   0..V_TOTAL-1          (stage -> generator)
//   active      inside the visible window            (stage -> generator)
//   line_start  first cycle of a line (x==0)         (stage -> generator)
//   frame_start first cycle of a frame (x==0,y==0)   (stage -> generator)
//   vblank      vertical blanking (y >= V_ACTIVE)    (stage -> generator)
//   rgb_in      {R1,R0,G1,G0,B1,B0}                  (generator -> stage)
//
// Modports
//   master : the output stage (drives the raster, consumes colour)
//   slave  : the pixel generator (consumes the raster, drives colour)
// ---------------------------------------------------------------------------
interface vga_out_stage_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       line_start;
  logic       frame_start;
  logic       vblank;
  logic [5:0] rgb_in;

  modport master (
    output x,
    output y,
    output active,
    output line_start,
    output frame_start,
    output vblank,
    input  rgb_in
  );

  modport slave (
    input  x,
    input  y,
    input  active,
    input  line_start,
    input  frame_start,
    input  vblank,
    output rgb_in
  );
endinterface

// File: rtl/vga_out_stage.sv
// ---------------------------------------------------------------------------
// vga_out_stage
//
// Final video stage. It free-runs a 640x480@60 raster (default timing)
// from the pixel clock and publishes the raster position to the pixel
// generator. It accepts that generator's colour PIX_LATENCY cycles later.
// Sync and blanking are delayed by the same amount, so all three line up.
// Colour is forced to zero outside the visible window. Everything is then
// registered into TinyVGA PMOD pin order on uo_out.
//
// Ports
//   clk     in   1  pixel clock
//   rst     in   1  synchronous reset, active-high
//   pix     --   -  vga_out_stage_if.master (raster out, rgb_in in)
//   uo_out  out  8  [7]=hsync [3]=vsync [0]=R1 [4]=R0 [1]=G1 [5]=G0
//                   [2]=B1 [6]=B0 ; syncs are active-low
//
// Latency: the colour for coordinate (x,y) issued at cycle t appears on
// uo_out from cycle t+PIX_LATENCY+1. Sync and blank edges carry the same
// offset.
// ---------------------------------------------------------------------------
module vga_out_stage #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PIX_LATENCY = 2     // legal 0..4
) (
  input  logic                   clk,
  input  logic                   rst,
  vga_out_stage_if.master        pix,
  output logic [7:0]             uo_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Flags that travel alongside the generator's latency.
  typedef struct packed {
    logic hs;   // active-low hsync
    logic vs;   // active-low vsync
    logic act;  // visible pixel
  } flags_t;

  // Idle value: both syncs released, nothing visible.
  localparam flags_t FLAGS_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

  // Reset value of the pin register: syncs released, colour black.
  localparam logic [7:0] UO_IDLE = 8'b1000_1000;

  // Map a sync pair and {R1,R0,G1,G0,B1,B0} colour onto the PMOD pins.
  function automatic logic [7:0] pack_pmod(input logic       hs,
                                           input logic       vs,
                                           input logic [5:0] col);
    logic [7:0] pins;
    pins    = '0;
    pins[7] = hs;
    pins[3] = vs;
    pins[0] = col[5];  // R1
    pins[4] = col[4];  // R0
    pins[1] = col[3];  // G1
    pins[5] = col[2];  // G0
    pins[2] = col[1];  // B1
    pins[6] = col[0];  // B0
    return pins;
  endfunction

  // Blank the colour outside the visible window. The select is explicit,
  // so an unknown colour during blanking never reaches the pins.
  function automatic logic [5:0] blank_colour(input logic       act,
                                              input logic [5:0] rgb);
    return act ? rgb : 6'd0;
  endfunction

  // -------------------------------------------------------------------------
  // Stage p0: raster counters and combinational decodes of the position
  // -------------------------------------------------------------------------
  logic [9:0] r_x;
  logic [9:0] r_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_x == H_LAST) begin
      r_x <= '0;
      r_y <= (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
    end else begin
      r_x <= r_x + 10'd1;
    end
  end

  logic   w_h_vis;
  logic   w_v_vis;
  flags_t w_raw_p0;

  assign w_h_vis      = (r_x < H_VIS);
  assign w_v_vis      = (r_y < V_VIS);
  assign w_raw_p0.hs  = ~((r_x >= HS_BEGIN) && (r_x < HS_END));
  assign w_raw_p0.vs  = ~((r_y >= VS_BEGIN) && (r_y < VS_END));
  assign w_raw_p0.act = w_h_vis && w_v_vis;

  assign pix.x           = r_x;
  assign pix.y           = r_y;
  assign pix.active      = w_raw_p0.act;
  assign pix.line_start  = (r_x == 10'd0);
  assign pix.frame_start = (r_x == 10'd0) && (r_y == 10'd0);
  assign pix.vblank      = ~w_v_vis;

  // -------------------------------------------------------------------------
  // Stage p1: align sync/active with the generator's latency
  // -------------------------------------------------------------------------
  flags_t w_dly_p1;

  generate
    if (PIX_LATENCY == 0) begin : g_no_delay
      // The generator answers combinationally, so the flags need no delay.
      assign w_dly_p1 = w_raw_p0;
    end else begin : g_delay
      flags_t r_dly_p1 [PIX_LATENCY];

      // Reset loads idle flags into every slot. No half-drawn line from
      // before the reset can then reach the pins.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PIX_LATENCY; i++) begin
            r_dly_p1[i] <= FLAGS_IDLE;
          end
        end else begin
          r_dly_p1[0] <= w_raw_p0;
          for (int i = 1; i < PIX_LATENCY; i++) begin
            r_dly_p1[i] <= r_dly_p1[i-1];
          end
        end
      end

      assign w_dly_p1 = r_dly_p1[PIX_LATENCY-1];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Stage p2: pin register (rgb_in sampled at the same edge as the flags)
  // -------------------------------------------------------------------------
  logic [5:0] w_col_p1;
  logic [7:0] r_uo_p2;

  assign w_col_p1 = blank_colour(w_dly_p1.act, pix.rgb_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_uo_p2 <= UO_IDLE;
    end else begin
      r_uo_p2 <= pack_pmod(w_dly_p1.hs, w_dly_p1.vs, w_col_p1);
    end
  end

  assign uo_out = r_uo_p2;

endmodule

// File: tb/tb_vga_out_stage.sv
module tb_vga_out_stage;

  // Reduced raster for the whole-frame scenarios (80 x 55 = 4400 cycles).
  localparam int SHA = 64, SHF = 4, SHS = 8, SHB = 4;
  localparam int SVA = 48, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int SFT = SHT * SVT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit xmode  = 1'b0;
  int lat_tab [4] = '{0, 1, 2, 4};

  logic [7:0] uo_big, uo_s0, uo_s1, uo_s2, uo_s4;

  vga_out_stage_if big_if ();
  vga_out_stage_if if_s0 ();
  vga_out_stage_if if_s1 ();
  vga_out_stage_if if_s2 ();
  vga_out_stage_if if_s4 ();

  vga_out_stage #(.PIX_LATENCY(2)) u_big (
    .clk(clk), .rst(rst), .pix(big_if), .uo_out(uo_big));

  vga_out_stage #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                  .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
                  .PIX_LATENCY(0)) u_s0 (
    .clk(clk), .rst(rst), .pix(if_s0), .uo_out(uo_s0));

  vga_out_stage #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                  .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
                  .PIX_LATENCY(1)) u_s1 (
    .clk(clk), .rst(rst), .pix(if_s1), .uo_out(uo_s1));

  vga_out_stage #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                  .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
                  .PIX_LATENCY(2)) u_s2 (
    .clk(clk), .rst(rst), .pix(if_s2), .uo_out(uo_s2));

  vga_out_stage #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                  .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
                  .PIX_LATENCY(4)) u_s4 (
    .clk(clk), .rst(rst), .pix(if_s4), .uo_out(uo_s4));

  // ---------------- reference model of the reduced raster ----------------
  function automatic int m_x(input int c);
    return (c % SFT) % SHT;
  endfunction

  function automatic int m_y(input int c);
    return (c % SFT) / SHT;
  endfunction

  function automatic bit m_act(input int c);
    return (m_x(c) < SHA) && (m_y(c) < SVA);
  endfunction

  function automatic logic [5:0] enc(input int c);
    return 6'(m_x(c) + m_y(c));
  endfunction

  // Expected pins at cycle t for latency L (pattern or xmode colour).
  function automatic logic [7:0] exp_uo(input int t, input int L, input bit xm);
    int c, x, y;
    logic hs, vs, act;
    logic [5:0] col;
    c = t - L - 1;
    if (c < 0) return 8'h88;
    x   = m_x(c);
    y   = m_y(c);
    hs  = !(x >= SHA + SHF && x < SHA + SHF + SHS);
    vs  = !(y >= SVA + SVF && y < SVA + SVF + SVS);
    act = (x < SHA) && (y < SVA);
    col = act ? (xm ? 6'b101010 : enc(c)) : 6'd0;
    return {hs, col[0], col[2], col[4], vs, col[1], col[3], col[5]};
  endfunction

  function automatic logic [7:0] get_uo(input int k);
    case (k)
      0:       return uo_s0;
      1:       return uo_s1;
      2:       return uo_s2;
      default: return uo_s4;
    endcase
  endfunction

  // Colour answered by the bench-side generators for the current cycle.
  task automatic drive_rgb();
    logic [5:0] v;
    int c;
    big_if.rgb_in = 6'b111111;
    for (int k = 0; k < 4; k++) begin
      c = cyc - lat_tab[k];
      if (xmode && k == 2)
        v = (c < 0 || !m_act(c)) ? 6'bxxxxxx : 6'b101010;
      else
        v = (c < 0) ? 6'd0 : enc(c);
      case (k)
        0:       if_s0.rgb_in = v;
        1:       if_s1.rgb_in = v;
        2:       if_s2.rgb_in = v;
        default: if_s4.rgb_in = v;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    drive_rgb();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    drive_rgb();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive_rgb();
    @(negedge clk);
    total++;
    if (uo_big !== 8'h88) $display("FAIL reset_uo_big: got %h want 88", uo_big);
    else passed++;
    total++;
    if (uo_s2 !== 8'h88) $display("FAIL reset_uo_s2: got %h want 88", uo_s2);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    drive_rgb();
    @(negedge clk);
    total++;
    if (big_if.x !== 10'd0 || big_if.y !== 10'd0)
      $display("FAIL rel_xy: got x=%0d y=%0d want 0 0", big_if.x, big_if.y);
    else passed++;
    total++;
    if (big_if.frame_start !== 1'b1 || big_if.line_start !== 1'b1)
      $display("FAIL rel_starts: got fs=%b ls=%b want 1 1",
               big_if.frame_start, big_if.line_start);
    else passed++;
    for (int t = 0; t < 3; t++) begin
      total++;
      if (uo_big !== 8'h88) $display("FAIL pre_pixel c%0d: got %h want 88", cyc, uo_big);
      else passed++;
      tick();
    end
    total++;
    if (uo_big !== 8'hFF) $display("FAIL first_pixel c3: got %h want ff", uo_big);
    else passed++;
  endtask

  task automatic test_line0();
    logic [5:0] col, ecol;
    logic ehs, els;
    while (cyc < 803) begin
      col  = {uo_big[0], uo_big[4], uo_big[1], uo_big[5], uo_big[2], uo_big[6]};
      ecol = (cyc >= 3 && cyc <= 642) ? 6'h3F : 6'h00;
      ehs  = !(cyc >= 659 && cyc < 755);
      els  = (cyc == 800);
      total++;
      if (col !== ecol) $display("FAIL line0_col c%0d: got %h want %h", cyc, col, ecol);
      else passed++;
      total++;
      if (uo_big[7] !== ehs || uo_big[3] !== 1'b1)
        $display("FAIL line0_sync c%0d: got hs=%b vs=%b want hs=%b vs=1",
                 cyc, uo_big[7], uo_big[3], ehs);
      else passed++;
      total++;
      if (big_if.line_start !== els)
        $display("FAIL line0_ls c%0d: got %b want %b", cyc, big_if.line_start, els);
      else passed++;
      if (cyc == 800) begin
        total++;
        if (big_if.x !== 10'd0 || big_if.y !== 10'd1)
          $display("FAIL line1_xy: got x=%0d y=%0d want 0 1", big_if.x, big_if.y);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_frame();
    int fs_cnt, vs_first, vs_cnt;
    fs_cnt = 0; vs_first = -1; vs_cnt = 0;
    do_reset(2);
    for (int t = 0; t <= SFT; t++) begin
      total++;
      if (if_s2.x !== 10'(m_x(t)) || if_s2.y !== 10'(m_y(t)))
        $display("FAIL frame_xy c%0d: got %0d,%0d want %0d,%0d",
                 t, if_s2.x, if_s2.y, m_x(t), m_y(t));
      else passed++;
      total++;
      if (if_s2.active !== m_act(t) || if_s2.vblank !== (m_y(t) >= SVA))
        $display("FAIL frame_act_vbl c%0d: got %b%b want %b%b", t,
                 if_s2.active, if_s2.vblank, m_act(t), (m_y(t) >= SVA));
      else passed++;
      total++;
      if (if_s2.line_start !== (m_x(t) == 0) ||
          if_s2.frame_start !== (m_x(t) == 0 && m_y(t) == 0))
        $display("FAIL frame_starts c%0d: got %b%b want %b%b", t,
                 if_s2.line_start, if_s2.frame_start, (m_x(t) == 0),
                 (m_x(t) == 0 && m_y(t) == 0));
      else passed++;
      if (t < SFT) begin
        if (if_s2.frame_start === 1'b1) fs_cnt++;
        if (uo_s2[3] === 1'b0) begin
          if (vs_first < 0) vs_first = t;
          vs_cnt++;
        end
      end
      tick();
    end
    total++;
    if (fs_cnt !== 1) $display("FAIL frame_fs_count: got %0d want 1", fs_cnt);
    else passed++;
    total++;
    if (vs_cnt !== SVS * SHT) $display("FAIL vsync_len: got %0d want %0d", vs_cnt, SVS * SHT);
    else passed++;
    total++;
    if (vs_first !== (SVA + SVF) * SHT + 3)
      $display("FAIL vsync_start: got %0d want %0d", vs_first, (SVA + SVF) * SHT + 3);
    else passed++;
  endtask

  task automatic test_latency();
    int hs_fall [4];
    logic [7:0] got, want;
    for (int k = 0; k < 4; k++) hs_fall[k] = -1;
    do_reset(2);
    for (int t = 0; t <= SFT + 8; t++) begin
      for (int k = 0; k < 4; k++) begin
        got  = get_uo(k);
        want = exp_uo(t, lat_tab[k], 1'b0);
        total++;
        if (got !== want)
          $display("FAIL lat%0d_pix c%0d: got %h want %h", lat_tab[k], t, got, want);
        else passed++;
        if (hs_fall[k] < 0 && got[7] === 1'b0) hs_fall[k] = t;
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (hs_fall[k] !== SHA + SHF + lat_tab[k] + 1)
        $display("FAIL lat%0d_hs_edge: got %0d want %0d", lat_tab[k], hs_fall[k],
                 SHA + SHF + lat_tab[k] + 1);
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] want;
    do_reset(2);
    while (cyc < 20 * SHT + 30) tick();
    total++;
    if (if_s2.x !== 10'd30 || if_s2.y !== 10'd20)
      $display("FAIL mid_pos: got %0d,%0d want 30,20", if_s2.x, if_s2.y);
    else passed++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    drive_rgb();
    @(negedge clk);
    total++;
    if (uo_s2 !== 8'h88 || uo_big !== 8'h88)
      $display("FAIL mid_uo: got %h/%h want 88/88", uo_s2, uo_big);
    else passed++;
    total++;
    if (if_s2.x !== 10'd0 || if_s2.y !== 10'd0 || if_s2.frame_start !== 1'b1)
      $display("FAIL mid_restart: got %0d,%0d fs=%b want 0,0 fs=1",
               if_s2.x, if_s2.y, if_s2.frame_start);
    else passed++;
    for (int t = 0; t <= SFT; t++) begin
      want = exp_uo(t, 2, 1'b0);
      total++;
      if (uo_s2 !== want || if_s2.x !== 10'(m_x(t)) || if_s2.y !== 10'(m_y(t)))
        $display("FAIL mid_frame c%0d: got %h %0d,%0d want %h %0d,%0d", t,
                 uo_s2, if_s2.x, if_s2.y, want, m_x(t), m_y(t));
      else passed++;
      tick();
    end
  endtask

  task automatic test_xprop();
    logic [7:0] want;
    xmode = 1'b1;
    do_reset(2);
    for (int t = 0; t <= SFT + 4; t++) begin
      want = exp_uo(t, 2, 1'b1);
      total++;
      if ($isunknown(uo_s2) || uo_s2 !== want)
        $display("FAIL xprop c%0d: got %h want %h", t, uo_s2, want);
      else passed++;
      tick();
    end
    xmode = 1'b0;
  endtask

  initial begin
    drive_rgb();
    test_reset();
    test_line0();
    test_frame();
    test_latency();
    test_mid_reset();
    test_xprop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_out_stage.md
Name: vga_out_stage

Overview:
- Final video stage of the canon design. Generates 640x480@60 VGA timing from the 25.175 MHz pixel clock.
- Publishes pixel coordinates to the upstream pixel generator and accepts that generator's 6-bit colour a fixed number of cycles later.
- Delays sync and blanking to match the generator's latency, forces colour to zero outside active video, and registers everything into the TinyVGA PMOD pin order driven on uo_out.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch
- PIX_LATENCY, 2, cycles from x/y to matching rgb_in; legal 0..4

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- x  out  10  current pixel column, 0..H_TOTAL-1
- y  out  10  current line, 0..V_TOTAL-1
- active  out  1  (x < H_ACTIVE) && (y < V_ACTIVE)
- line_start  out  1  high for the one cycle where x==0
- frame_start  out  1  high for the one cycle where x==0 && y==0
- vblank  out  1  y >= V_ACTIVE
- rgb_in  in  6  {R1,R0,G1,G0,B1,B0} for the coordinate issued PIX_LATENCY cycles earlier
- uo_out  out  8  [7]=hsync, [3]=vsync, [0]=R1, [4]=R0, [1]=G1, [5]=G0, [2]=B1, [6]=B0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- x and y are registered counters.
  - x increments every cycle; at H_TOTAL-1 it wraps to 0 and y increments.
  - y wraps to 0 when x wraps while y==V_TOTAL-1.
  - Frame length is 420000 cycles.
- active, line_start, frame_start and vblank are combinational decodes of the current x/y. They are valid in the same cycle as x/y.
- Raw sync is active-low (negative polarity):
  - hsync_raw = 0 when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, i.e. x in 656..751.
  - vsync_raw = 0 when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, i.e. y in 490..491, for all x on those lines.
- Alignment pipeline:
  - {hsync_raw, vsync_raw, active} pass through a PIX_LATENCY-deep shift register.
  - With PIX_LATENCY=0 the stage is a wire.
- Output register, updated every cycle:
  - hsync and vsync bits take the delayed sync values.
  - Colour bits take rgb_in when the delayed active is 1, otherwise 0.
  - rgb_in is sampled at the same edge as the delayed flags.
- Latency: the pixel for coordinate (x,y) issued at cycle t appears on uo_out from cycle t+PIX_LATENCY+1. Sync and blanking edges carry the identical offset.
- Reset, on any rising clk with rst=1, including mid-frame:
  - x=0, y=0.
  - All delay stages load hsync=1, vsync=1, active=0.
  - uo_out = 8'b1000_1000: syncs inactive, colour 0.
  - The first cycle after reset deasserts presents x=0, y=0 with frame_start=1.
  - No partial-line state survives reset.
- rgb_in is ignored (treated as 0) whenever the delayed active is 0, so X on rgb_in during blanking must not propagate to uo_out.
- No enable input. The block free-runs from reset.

Test Plan:
- Reset for 3 cycles then release, PIX_LATENCY=2:
  - uo_out==8'h88 during reset.
  - Cycle 0 after release: x=0, y=0, frame_start=1, line_start=1.
  - uo_out colour bits first follow rgb_in at cycle 3.
- Drive rgb_in=6'b111111 constantly:
  - On line 0, colour bits are all 1 for output cycles 3..642 and 0 from 643.
  - hsync (uo_out[7]) falls at cycle 659 and rises at cycle 755.
  - Next line_start is at cycle 800.
- Run one full frame:
  - frame_start pulses exactly once per 420000 cycles.
  - vsync (uo_out[3]) is low for exactly 1600 cycles, starting 490*800+3 cycles after frame_start.
  - vblank is high for lines 480..524.
- Drive rgb_in with a pattern encoding the issued x, delayed by PIX_LATENCY in the bench:
  - Repeat for PIX_LATENCY = 0, 1 and 4.
  - Each output pixel matches its coordinate; sync edges shift by exactly PIX_LATENCY.
- Assert rst at x=300, y=200 for one cycle:
  - The next edge gives uo_out=8'h88.
  - The cycle after release has x=0, y=0, frame_start=1.
  - The following frame timing is identical to the post-power-on timing.
- Drive rgb_in=6'bxxxxxx during blanking (x>=640 or y>=480) and 6'b101010 during active video:
  - No X ever appears on uo_out.
  - Active pixels read uo_out[0]=1, [4]=0, [1]=1, [5]=0, [2]=1, [6]=0.
